// File: rtl/branch_predictor_unit.sv
// branch_predictor_unit: direct-mapped BHT with per-entry targets for fetch
// prediction, plus EX-stage branch resolution and mispredict redirect.
// Optional macro BRANCH_PERF_EN adds Perf_Branches / Perf_Mispredicts counters.
//
// Interface semantics: there is no handshake. Ex_Valid qualifies every Ex_*
// input for the current cycle only; with Ex_Valid low the EX side neither
// redirects nor updates the table. The lookup side is always live and
// combinational on F_PC.
module branch_predictor_unit #(
  parameter int PC_W      = 9,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] F_PC,
  output logic            Pred_Taken,
  output logic [31:0]     Pred_Target,
  input  logic            Ex_Valid,
  input  logic [PC_W-1:0] Ex_PC,
  input  logic            Ex_Branch,
  input  logic            Ex_Jalr,
  input  logic [31:0]     Ex_AluResult,
  input  logic [31:0]     Ex_Imm,
  input  logic            Ex_PredTaken,
  input  logic [31:0]     Ex_PredTarget,
  output logic [31:0]     PC_Four,
  output logic [31:0]     BrPC,
  output logic            PcSel
`ifdef BRANCH_PERF_EN
  ,
  output logic [31:0]     Perf_Branches,
  output logic [31:0]     Perf_Mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MIN = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_WT  = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_WNT = {1'b0, {(CNT_W-1){1'b1}}};

  logic             valid_q [BHT_DEPTH];
  logic             valid_d [BHT_DEPTH];
  logic [TAG_W-1:0] tag_q   [BHT_DEPTH];
  logic [TAG_W-1:0] tag_d   [BHT_DEPTH];
  logic [CNT_W-1:0] cnt_q   [BHT_DEPTH];
  logic [CNT_W-1:0] cnt_d   [BHT_DEPTH];
  logic [31:0]      tgt_q   [BHT_DEPTH];
  logic [31:0]      tgt_d   [BHT_DEPTH];

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit, e_hit;
  logic [31:0]      f_pc32, e_pc32, act_tgt;
  logic             act_taken, mispredict;

  // Fetch-side lookup: reads the registered table, so a same-cycle update is not seen.
  always_comb begin
    f_idx       = F_PC[IDX_W+1:2];
    f_tag       = F_PC[PC_W-1:IDX_W+2];
    f_pc32      = {{(32-PC_W){1'b0}}, F_PC};
    f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    Pred_Taken  = f_hit && cnt_q[f_idx][CNT_W-1];
    Pred_Target = Pred_Taken ? tgt_q[f_idx] : f_pc32 + 32'd4;
  end

  // EX-side resolution: actual outcome vs. the prediction carried with the instruction.
  always_comb begin
    e_idx      = Ex_PC[IDX_W+1:2];
    e_tag      = Ex_PC[PC_W-1:IDX_W+2];
    e_pc32     = {{(32-PC_W){1'b0}}, Ex_PC};
    e_hit      = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    PC_Four    = e_pc32 + 32'd4;
    act_taken  = Ex_Branch && (Ex_AluResult[0] || Ex_Jalr);
    act_tgt    = Ex_Jalr ? e_pc32 + Ex_AluResult : e_pc32 + Ex_Imm;
    mispredict = !reset && Ex_Valid &&
                 ((act_taken != Ex_PredTaken) || (act_taken && (act_tgt != Ex_PredTarget)));
    PcSel      = mispredict;
    BrPC       = mispredict ? (act_taken ? act_tgt : PC_Four) : 32'd0;
  end

  // Next table contents: train/allocate on resolved branches, drop aliased entries.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    if (Ex_Valid && Ex_Branch) begin
      if (e_hit) begin
        if (act_taken) begin
          if (cnt_q[e_idx] != CNT_MAX) cnt_d[e_idx] = cnt_q[e_idx] + CNT_ONE;
          tgt_d[e_idx] = act_tgt;
        end else if (cnt_q[e_idx] != CNT_MIN) begin
          cnt_d[e_idx] = cnt_q[e_idx] - CNT_ONE;
        end
      end else if (act_taken) begin
        valid_d[e_idx] = 1'b1;
        tag_d[e_idx]   = e_tag;
        tgt_d[e_idx]   = act_tgt;
        cnt_d[e_idx]   = CNT_WT;
      end
    end else if (Ex_Valid && Ex_PredTaken && e_hit) begin
      // A non-branch hit a taken entry: the entry belongs to another PC, retire it.
      valid_d[e_idx] = 1'b0;
    end
  end

  // Table registers; reset clears every entry in one cycle and drops any EX update.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        cnt_q[i]   <= CNT_WNT;
        tgt_q[i]   <= 32'd0;
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

`ifdef BRANCH_PERF_EN
  logic [31:0] perf_br_q, perf_br_d, perf_mis_q, perf_mis_d;

  // Saturating event counters for resolved branches and redirects.
  always_comb begin
    perf_br_d  = perf_br_q;
    perf_mis_d = perf_mis_q;
    if (Ex_Valid && Ex_Branch && (perf_br_q != 32'hFFFF_FFFF)) perf_br_d = perf_br_q + 32'd1;
    if (mispredict && (perf_mis_q != 32'hFFFF_FFFF)) perf_mis_d = perf_mis_q + 32'd1;
  end

  // Counter registers, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_br_q  <= 32'd0;
      perf_mis_q <= 32'd0;
    end else begin
      perf_br_q  <= perf_br_d;
      perf_mis_q <= perf_mis_d;
    end
  end

  assign Perf_Branches    = perf_br_q;
  assign Perf_Mispredicts = perf_mis_q;
`endif

endmodule

// File: tb/tb_branch_predictor_unit.sv
// tb_branch_predictor_unit: directed scenarios followed by random traffic,
// checked against a table-of-entries reference model via an expected queue.
module tb_branch_predictor_unit;

  localparam int EW = 98; // {pred_taken, pred_target, pc_four, brpc, pcsel}

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  F_PC, Ex_PC;
  logic        Pred_Taken, Ex_Valid, Ex_Branch, Ex_Jalr, Ex_PredTaken, PcSel;
  logic [31:0] Pred_Target, Ex_AluResult, Ex_Imm, Ex_PredTarget, PC_Four, BrPC;
`ifdef BRANCH_PERF_EN
  logic [31:0] Perf_Branches, Perf_Mispredicts;
`endif

  always #5 clk = ~clk;

  branch_predictor_unit dut (
    .clk(clk), .reset(reset), .F_PC(F_PC),
    .Pred_Taken(Pred_Taken), .Pred_Target(Pred_Target),
    .Ex_Valid(Ex_Valid), .Ex_PC(Ex_PC), .Ex_Branch(Ex_Branch), .Ex_Jalr(Ex_Jalr),
    .Ex_AluResult(Ex_AluResult), .Ex_Imm(Ex_Imm),
    .Ex_PredTaken(Ex_PredTaken), .Ex_PredTarget(Ex_PredTarget),
    .PC_Four(PC_Four), .BrPC(BrPC), .PcSel(PcSel)
`ifdef BRANCH_PERF_EN
    , .Perf_Branches(Perf_Branches), .Perf_Mispredicts(Perf_Mispredicts)
`endif
  );

  // ---------------- reference model ----------------
  bit          m_valid [16];
  int          m_tag   [16];
  int          m_cnt   [16];   // 0..3, taken when >= 2
  logic [31:0] m_tgt   [16];
  int          m_br, m_mis;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_cnt[i] = 1; m_tgt[i] = 32'd0;
    end
    m_br = 0; m_mis = 0;
  endfunction

  function automatic bit model_hit(input logic [8:0] pc);
    int i = (int'(pc) / 4) % 16;
    return m_valid[i] && (m_tag[i] == int'(pc) / 64);
  endfunction

  function automatic void predict(input logic [8:0] pc, output bit pt, output logic [31:0] tg);
    int i = (int'(pc) / 4) % 16;
    pt = model_hit(pc) && (m_cnt[i] >= 2);
    tg = pt ? m_tgt[i] : 32'(pc) + 32'd4;
  endfunction

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle against the queued expectation.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pred_taken",  {31'd0, Pred_Taken}, {31'd0, e[97]});
      check("pred_target", Pred_Target,         e[96:65]);
      check("pc_four",     PC_Four,             e[64:33]);
      check("brpc",        BrPC,                e[32:1]);
      check("pcsel",       {31'd0, PcSel},      {31'd0, e[0]});
    end
  end

  // ---------------- driver ----------------
  task automatic step(input bit chk, input bit rst, input logic [8:0] fpc,
                      input bit ev, input logic [8:0] epc, input bit br, input bit jr,
                      input logic [31:0] alu, input logic [31:0] imm,
                      input bit ptk, input logic [31:0] ptgt);
    bit          f_pt, at, mis, hit;
    logic [31:0] f_tg, pcf, tgt, brpc;
    int          i;
    reset = rst; F_PC = fpc; Ex_Valid = ev; Ex_PC = epc; Ex_Branch = br; Ex_Jalr = jr;
    Ex_AluResult = alu; Ex_Imm = imm; Ex_PredTaken = ptk; Ex_PredTarget = ptgt;
    predict(fpc, f_pt, f_tg);
    pcf  = 32'(epc);
    at   = br && (alu[0] || jr);
    tgt  = jr ? pcf + alu : pcf + imm;
    mis  = !rst && ev && ((at != ptk) || (at && tgt != ptgt));
    brpc = !mis ? 32'd0 : (at ? tgt : pcf + 32'd4);
    if (chk) exp_q.push_back({f_pt, f_tg, pcf + 32'd4, brpc, mis});
    hit = model_hit(epc);
    i   = (int'(epc) / 4) % 16;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (ev && br) m_br++;
      if (mis) m_mis++;
      if (ev && br && hit) begin
        if (at) begin
          m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
          m_tgt[i] = tgt;
        end else begin
          m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
        end
      end else if (ev && br && at) begin
        m_valid[i] = 1; m_tag[i] = int'(epc) / 64; m_tgt[i] = tgt; m_cnt[i] = 2;
      end else if (ev && !br && ptk && hit) begin
        m_valid[i] = 0;
      end
    end
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit          pt;
    logic [31:0] tg, alu, imm;
    logic [8:0]  epc;
    model_reset();
    // Power-on reset: table is unknown before this edge, so nothing is checked.
    step(0, 1, 9'h040, 0, 9'h0, 0, 0, 32'd0, 32'd0, 0, 32'd0);
    // Reset held with a branch in EX: redirect suppressed, update dropped.
    step(1, 1, 9'h040, 1, 9'h040, 1, 0, 32'd1, 32'h20, 0, 32'd0);
    step(1, 0, 9'h040, 0, 9'h000, 0, 0, 32'd0, 32'd0, 0, 32'd0);
    // Cold taken branch, same-cycle lookup of the same index sees old contents.
    step(1, 0, 9'h040, 1, 9'h040, 1, 0, 32'd1, 32'h20, 0, 32'd0);
    // Correctly predicted twice: counter climbs and saturates.
    step(1, 0, 9'h040, 1, 9'h040, 1, 0, 32'd1, 32'h20, 1, 32'h60);
    step(1, 0, 9'h040, 1, 9'h040, 1, 0, 32'd1, 32'h20, 1, 32'h60);
    // Hysteresis: two not-taken resolves.
    step(1, 0, 9'h040, 1, 9'h040, 1, 0, 32'd0, 32'h20, 1, 32'h60);
    step(1, 0, 9'h040, 1, 9'h040, 1, 0, 32'd0, 32'h20, 1, 32'h60);
    step(1, 0, 9'h040, 0, 9'h000, 0, 0, 32'd0, 32'd0, 0, 32'd0);
    // JALR with a wrong predicted target.
    step(1, 0, 9'h080, 1, 9'h080, 1, 1, 32'h100, 32'd0, 1, 32'h200);
    step(1, 0, 9'h080, 0, 9'h000, 0, 0, 32'd0, 32'd0, 0, 32'd0);
    // Non-branch predicted taken at a live entry: redirect to PC+4, entry dropped.
    step(1, 0, 9'h080, 1, 9'h080, 0, 0, 32'd0, 32'd0, 1, 32'h180);
    step(1, 0, 9'h080, 0, 9'h000, 0, 0, 32'd0, 32'd0, 0, 32'd0);
    // Ex_Valid low with a would-be mispredict: ignored.
    step(1, 0, 9'h040, 0, 9'h040, 1, 1, 32'hFFFF, 32'h44, 1, 32'h0);

    // Random traffic over a small PC pool to force hits, aliasing and evictions.
    for (int n = 0; n < 3000; n++) begin
      epc = {3'($urandom_range(0, 2)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      alu = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 511));
      imm = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 127)) << 1;
      if ($urandom_range(0, 1) == 1) predict(epc, pt, tg);
      else begin pt = 1'($urandom_range(0, 1)); tg = 32'($urandom_range(0, 1023)); end
      step(1, $urandom_range(0, 99) == 0,
           {3'($urandom_range(0, 2)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3))},
           $urandom_range(0, 7) != 0, epc, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0, alu, imm, pt, tg);
    end
    step(1, 0, 9'h000, 0, 9'h000, 0, 0, 32'd0, 32'd0, 0, 32'd0);

    @(negedge clk);
    #1;
`ifdef BRANCH_PERF_EN
    check("perf_branches",    Perf_Branches,    32'(m_br));
    check("perf_mispredicts", Perf_Mispredicts, 32'(m_mis));
`endif
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
